simd_acc_shift: RTL and testbench



---
 rtl/simd_acc_shift.sv | 111 +++++++++++
 tb/tb_simd_acc_shift.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_acc_shift.sv
// Per-lane accumulate-and-requantize stage: sums cfg_len signed beats into an
// ACC_W accumulator, then applies a rounding arithmetic right shift.
module simd_acc_shift #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [4:0]        cfg_shift,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [4:0]       shift_q, shift_d;
   logic [ACC_W-1:0] outData_q, outData_d;
   logic             outValid_q, outValid_d;

   logic                    accept;
   logic                    firstBeat;
   logic                    finalBeat;
   logic [LEN_W-1:0]        lenSel;
   logic [4:0]              shiftSel;
   logic [LEN_W:0]          cntInc;
   logic [ACC_W-1:0]        beatExt;
   logic [ACC_W-1:0]        sum;
   logic [ACC_W-1:0]        bias;
   logic signed [ACC_W-1:0] biased;
   logic [ACC_W-1:0]        rounded;

   assign in_ready  = !clear && !(outValid_q && !out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   // The first beat of a group uses live config; later beats use the latched copy.
   always_comb begin
      firstBeat = (cnt_q == '0);
      lenSel    = len_q;
      shiftSel  = shift_q;
      if (firstBeat) begin
         lenSel   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
         shiftSel = cfg_shift;
      end
      beatExt   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      sum       = firstBeat ? beatExt : (acc_q + beatExt);
      cntInc    = {1'b0, cnt_q} + (LEN_W+1)'(1);
      finalBeat = (cntInc == {1'b0, lenSel});
      bias      = (shiftSel == 5'd0) ? '0 : (ACC_W'(1) << (shiftSel - 5'd1));
      biased    = sum + bias;
      rounded   = biased >>> shiftSel;
   end

   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      shift_d    = shift_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      if (out_ready) begin
         outValid_d = 1'b0;
      end
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (firstBeat) begin
            len_d   = lenSel;
            shift_d = shiftSel;
         end
         if (finalBeat) begin
            acc_d      = '0;
            cnt_d      = '0;
            outData_d  = rounded;
            outValid_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cntInc[LEN_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= LEN_W'(1);
         shift_q    <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         shift_q    <= shift_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
      end
   end

endmodule

// File: tb/tb_simd_acc_shift.sv
// Directed and randomized bench for simd_acc_shift; expected results come from
// whole-group sums, wrapped and rounded arithmetically.
module tb_simd_acc_shift;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int LEN_W  = 16;
   localparam longint TWO32 = longint'(1) <<< 32;
   localparam longint TWO31 = longint'(1) <<< 31;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [LEN_W-1:0]  cfg_len;
   logic [4:0]        cfg_shift;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;

   int checks = 0;
   int errors = 0;

   logic        lastAcc, lastDrain, lastHold, lastReady, lastExpReady;
   logic [31:0] lastData;

   typedef struct {
      logic [15:0] d;
      logic        first;
      logic [15:0] len;
      logic [4:0]  sh;
   } beat_t;

   beat_t       beats[$];
   logic [31:0] expQ[$];

   simd_acc_shift #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
      .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   function automatic longint wrapAcc(input longint x);
      longint m;
      m = x % TWO32;
      if (m < 0) m = m + TWO32;
      if (m >= TWO31) m = m - TWO32;
      return m;
   endfunction

   // Sum wrapped to ACC_W, then round half toward +inf via floor division.
   function automatic logic [31:0] refResult(input longint total, input int sh);
      longint s, t, d, q;
      s = wrapAcc(total);
      if (sh == 0) return s[31:0];
      t = wrapAcc(s + (longint'(1) <<< (sh - 1)));
      d = longint'(1) <<< sh;
      q = t / d;
      if ((t % d != 0) && (t < 0)) q = q - 1;
      return q[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic ordy, input logic clr);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      clear     = clr;
      #1;
      lastAcc      = in_valid && in_ready;
      lastDrain    = out_valid && out_ready;
      lastHold     = out_valid && !out_ready;
      lastData     = out_data;
      lastReady    = in_ready;
      lastExpReady = !clr && !(out_valid && !ordy);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      reset_n = 1'b0; cfg_len = 16'd1; cfg_shift = 5'd0;
      clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_data", out_data, 32'd0);
      checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Basic four-beat accumulate, output pulses for exactly one cycle.
      cfg_len = 16'd4; cfg_shift = 5'd0;
      applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
      checkOutput("len4_early", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b1, 16'd4, 1'b1, 1'b0);
      checkOutput("len4_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("len4_data", out_data, 32'd10);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("len4_pulse", {31'd0, out_valid}, 32'd0);

      // Rounding cases.
      cfg_len = 16'd2; cfg_shift = 5'd2;
      applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
      checkOutput("rnd_pos", out_data, 32'd1);
      applyStimulus(1'b1, 16'hFFFD, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'hFFFE, 1'b1, 1'b0);
      checkOutput("rnd_neg", out_data, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 16'd4, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
      checkOutput("rnd_half", out_data, 32'd2);
      cfg_len = 16'd1; cfg_shift = 5'd31;
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      checkOutput("rnd_sh31_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("rnd_sh31", out_data, 32'd0);

      // Backpressure: stall, hold, then drain and refill in one cycle.
      cfg_shift = 5'd0;
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
      checkOutput("bp_first", out_data, 32'd5);
      checkOutput("bp_ready_low", {31'd0, in_ready}, 32'd0);
      repeat (2) begin
         applyStimulus(1'b1, 16'd6, 1'b0, 1'b0);
         checkOutput("bp_no_accept", {31'd0, lastAcc}, 32'd0);
         checkOutput("bp_hold_data", out_data, 32'd5);
         checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      applyStimulus(1'b1, 16'd6, 1'b1, 1'b0);
      checkOutput("bp_refill_acc", {31'd0, lastAcc}, 32'd1);
      checkOutput("bp_refill_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_refill_data", out_data, 32'd6);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

      // Clear keeps the pending output and discards the partial group.
      applyStimulus(1'b1, 16'd9, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd50, 1'b0, 1'b1);
      checkOutput("clr_pending_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("clr_pending_data", out_data, 32'd9);
      cfg_len = 16'd3;
      applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd200, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd50, 1'b1, 1'b1);
      checkOutput("clr_no_accept", {31'd0, lastAcc}, 32'd0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      checkOutput("clr_early", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      checkOutput("clr_sum", out_data, 32'd21);

      // Zero length behaves as one.
      cfg_len = 16'd0;
      applyStimulus(1'b1, 16'd11, 1'b1, 1'b0);
      checkOutput("len0_a", out_data, 32'd11);
      applyStimulus(1'b1, 16'hFFF4, 1'b1, 1'b0);
      checkOutput("len0_b", out_data, 32'hFFFF_FFF4);

      // Long group; rounding bias overflows ACC_W. Mid-group config changes are ignored.
      cfg_len = 16'd65535; cfg_shift = 5'd31;
      applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
      cfg_len = 16'd2; cfg_shift = 5'd0;
      for (int i = 0; i < 65533; i++) applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
      checkOutput("wrap_early", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
      checkOutput("wrap_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("wrap_data", out_data, refResult(longint'(65535) * 32767, 31));
      applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
      checkOutput("wrap_tail", out_data, refResult(longint'(2) * 32767, 0));

      // Async reset with a pending output, then mid-group.
      cfg_len = 16'd1;
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_data", out_data, 32'd0);
      checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1 reset_n = 1'b1;
      cfg_len = 16'd3;
      applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      checkOutput("rst_regroup", out_data, 32'd21);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Randomized groups with random valid/ready against whole-group reference sums.
      for (int g = 0; g < 60; g++) begin
         int cl, sh, n;
         longint s;
         beat_t b;
         cl = $urandom_range(0, 5);
         sh = $urandom_range(0, 31);
         n  = (cl == 0) ? 1 : cl;
         s  = 0;
         for (int k = 0; k < n; k++) begin
            b.d     = 16'($urandom);
            b.first = (k == 0);
            b.len   = 16'(cl);
            b.sh    = 5'(sh);
            s       = s + longint'($signed(b.d));
            beats.push_back(b);
         end
         expQ.push_back(refResult(s, sh));
      end
      cyc = 0;
      while ((beats.size() > 0 || expQ.size() > 0) && cyc < 5000) begin
         logic        v, ordy;
         logic [15:0] d;
         v = (beats.size() > 0) && ($urandom_range(0, 3) != 0);
         d = 16'($urandom);
         cfg_len   = 16'($urandom);
         cfg_shift = 5'($urandom);
         if (v) begin
            d = beats[0].d;
            if (beats[0].first) begin
               cfg_len   = beats[0].len;
               cfg_shift = beats[0].sh;
            end
         end
         ordy = ($urandom_range(0, 3) != 0);
         applyStimulus(v, d, ordy, 1'b0);
         checkOutput("rand_in_ready", {31'd0, lastReady}, {31'd0, lastExpReady});
         if (lastHold) begin
            checkOutput("rand_hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("rand_hold_data", out_data, lastData);
         end
         if (lastAcc) void'(beats.pop_front());
         if (lastDrain) begin
            if (expQ.size() == 0) checkOutput("rand_extra_output", 32'd1, 32'd0);
            else checkOutput("rand_result", lastData, expQ.pop_front());
         end
         cyc++;
      end
      checkOutput("rand_outstanding", 32'(beats.size() + expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
